// File: rtl/rv_pkg.sv
// Shared definitions for the single-cycle RISC-V core.
//   XLEN      : datapath width.
//   wb_sel_e  : write-back select encodings driven by the control unit.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        WB_MEM = 2'b00,
        WB_ALU = 2'b01,
        WB_PC4 = 2'b10,
        WB_RSV = 2'b11
    } wb_sel_e;

endpackage

// File: rtl/dmem.sv
// Word-addressed data memory.
// Ports:
//   clk   : rising-edge clock.
//   rst   : synchronous active-low reset; clears every word.
//   we    : write enable, ignored while rst is low.
//   addr  : word index.
//   wdata : store data.
//   rdata : combinational read data at addr (old value during a write cycle).
module dmem #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Reset wins over a simultaneous store.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/wb_module.sv
// Write-back stage: owns data memory and selects the register-file write value.
// Ports:
//   clk      : rising-edge clock.
//   rst      : synchronous active-low reset (clears data memory).
//   MemRW    : 1 = store Wr_data at alu_out.
//   WBSel    : 00 memory, 01 ALU, 10 PC+4, 11 zero.
//   alu_out  : ALU result, also the byte address into data memory.
//   Wr_data  : store data (rs2).
//   pc_plus4 : return address for JAL/JALR.
//   WB_Data  : combinational value written into rd.
module wb_module #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemRW,
    input  logic [1:0]      WBSel,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] Wr_data,
    input  logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] WB_Data
);

    import rv_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    logic [XLEN-1:0] mem_rdata;

    // Byte offset and bits above the memory size are dropped: word-only, wrapping access.
    dmem #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN),
        .AW    (AW)
    ) u_dmem (
        .clk   (clk),
        .rst   (rst),
        .we    (MemRW),
        .addr  (alu_out[AW+1:2]),
        .wdata (Wr_data),
        .rdata (mem_rdata)
    );

    always_comb begin
        WB_Data = '0;
        unique case (wb_sel_e'(WBSel))
            WB_MEM:  WB_Data = mem_rdata;
            WB_ALU:  WB_Data = alu_out;
            WB_PC4:  WB_Data = pc_plus4;
            WB_RSV:  WB_Data = '0;
            default: WB_Data = '0;
        endcase
    end

endmodule

// File: tb/tb_wb_module.sv
module tb_wb_module;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRW;
    logic [1:0]  WBSel;
    logic [31:0] alu_out;
    logic [31:0] Wr_data;
    logic [31:0] pc_plus4;
    logic [31:0] WB_Data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [DEPTH];

    wb_module #(
        .DEPTH (DEPTH),
        .XLEN  (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MemRW    (MemRW),
        .WBSel    (WBSel),
        .alu_out  (alu_out),
        .Wr_data  (Wr_data),
        .pc_plus4 (pc_plus4),
        .WB_Data  (WB_Data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        memrw;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        bit          chk;
        bit          tick;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic m, logic [1:0] s, logic [31:0] a,
                                logic [31:0] w, logic [31:0] p, bit c, bit t,
                                logic [31:0] e);
        vec_t v;
        v.rst = r; v.memrw = m; v.sel = s; v.alu = a; v.wd = w; v.pc4 = p;
        v.chk = c; v.tick = t; v.exp = e;
        return v;
    endfunction

    // Reference: byte address modulo DEPTH*4, word granularity.
    function automatic logic [31:0] expected();
        case (WBSel)
            2'b00:   return model[(alu_out / 4) % DEPTH];
            2'b01:   return alu_out;
            2'b10:   return pc_plus4;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(logic r, logic m, logic [1:0] s, logic [31:0] a,
                         logic [31:0] w, logic [31:0] p);
        rst = r; MemRW = m; WBSel = s; alu_out = a; Wr_data = w; pc_plus4 = p;
        #1;
    endtask

    task automatic check(string name, logic [31:0] exp);
        checks++;
        if (WB_Data !== exp) begin
            failures++;
            $display("FAIL %s: WB_Data=%08h expected=%08h (sel=%0d alu=%08h)",
                     name, WB_Data, exp, WBSel, alu_out);
        end
    endtask

    // Advance one edge and apply the same edge to the model.
    task automatic tick();
        logic        r = rst;
        logic        m = MemRW;
        logic [31:0] a = alu_out;
        logic [31:0] w = Wr_data;
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        end else if (m) begin
            model[(a / 4) % DEPTH] = w;
        end
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 2'b01, 32'h0, 32'h0, 32'h0);
        @(negedge clk);

        vecs.push_back(mk(0, 0, 2'b00, 32'h4,   32'h0,        32'h8,  0, 1, 32'h0));
        vecs.push_back(mk(1, 0, 2'b00, 32'h4,   32'h0,        32'h8,  1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 2'b01, 32'h4,   32'h0,        32'h8,  1, 0, 32'h4));
        vecs.push_back(mk(1, 0, 2'b10, 32'h4,   32'h0,        32'h8,  1, 0, 32'h8));
        vecs.push_back(mk(1, 1, 2'b00, 32'h10,  32'hDEADBEEF, 32'h8,  1, 1, 32'h0));
        vecs.push_back(mk(1, 0, 2'b00, 32'h10,  32'h0,        32'h8,  1, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 2'b00, 32'h14,  32'h0,        32'h8,  1, 0, 32'h0));
        vecs.push_back(mk(1, 1, 2'b00, 32'h20,  32'h12345678, 32'h8,  1, 1, 32'h0));
        vecs.push_back(mk(1, 0, 2'b00, 32'h23,  32'h0,        32'h8,  1, 0, 32'h12345678));
        vecs.push_back(mk(1, 0, 2'b00, 32'h420, 32'h0,        32'h8,  1, 0, 32'h12345678));
        vecs.push_back(mk(1, 1, 2'b11, 32'h20,  32'h5,        32'h99, 1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 2'b00, 32'h20,  32'h0,        32'h8,  1, 0, 32'h12345678));
        vecs.push_back(mk(0, 1, 2'b00, 32'h30,  32'hFFFFFFFF, 32'h8,  0, 1, 32'h0));
        vecs.push_back(mk(1, 0, 2'b00, 32'h30,  32'h0,        32'h8,  1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 2'b00, 32'h10,  32'h0,        32'h8,  1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 2'b00, 32'h20,  32'h0,        32'h8,  1, 0, 32'h0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].memrw, vecs[i].sel, vecs[i].alu, vecs[i].wd, vecs[i].pc4);
            if (vecs[i].chk) check($sformatf("vec%0d", i), vecs[i].exp);
            if (vecs[i].tick) tick();
        end

        // Read-during-write on a word holding a non-zero value.
        drive(1, 1, 2'b00, 32'h50, 32'hAAAA5555, 32'h0); tick();
        drive(1, 1, 2'b00, 32'h50, 32'hBBBB6666, 32'h0);
        check("rdw_old", 32'hAAAA5555);
        tick();
        check("rdw_new", 32'hBBBB6666);

        // Reset held low over several edges while stores are attempted.
        drive(1, 1, 2'b00, 32'h40, 32'hCAFEF00D, 32'h0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 2'b00, 32'h40 + 32'(i * 4), 32'h11110000 + 32'(i), 32'h0);
            tick();
        end
        drive(1, 0, 2'b00, 32'h40, 32'h0, 32'h0); check("rst_hold_w16", 32'h0);
        drive(1, 0, 2'b00, 32'h44, 32'h0, 32'h0); check("rst_hold_w17", 32'h0);
        drive(1, 0, 2'b00, 32'h50, 32'h0, 32'h0); check("rst_hold_w20", 32'h0);

        // Randomized traffic against the model; addresses biased to a small window.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0),
                  2'($urandom_range(0, 3)), a, $urandom, $urandom);
            check("rand", expected());
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
